// File: rtl/dot_matrix_scan_ctrl.sv
// Row-scan scheduler for an 8x8 LED matrix: double-buffered frame, tear-free commit, blanking between rows.
// Optional per-row PWM dimming via the brightness port when MATRIX_DIM_EN is defined.
module dot_matrix_scan_ctrl #(
  parameter int ROW_HOLD  = 1000,
  parameter int BLANK_CYC = 2,
  parameter int COL_INV   = 0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [2:0] wr_row,
  input  logic [7:0] wr_data,
  input  logic       commit,
  output logic       commit_pending,
  output logic       frame_tick,
  output logic [7:0] dot_row,
  output logic [7:0] dot_col
`ifdef MATRIX_DIM_EN
  ,
  input  logic [2:0] brightness
`endif
);

  localparam int CNT_MAX = (ROW_HOLD > BLANK_CYC) ? ROW_HOLD : BLANK_CYC;
  localparam int CW      = $clog2(CNT_MAX);

  localparam logic [CW-1:0] HOLD_LAST  = CW'(ROW_HOLD - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
  localparam logic [7:0]    COL_OFF    = (COL_INV != 0) ? 8'hFF : 8'h00;

  localparam logic [0:0] ST_BLANK = 1'b0;
  localparam logic [0:0] ST_DRIVE = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [2:0]    row_idx_q, row_idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    front_q [8];
  logic [7:0]    front_d [8];
  logic [7:0]    back_q  [8];
  logic [7:0]    back_d  [8];
  logic          pending_q, pending_d;
  logic          frame_tick_q, frame_tick_d;
  logic [7:0]    dot_row_q, dot_row_d;
  logic [7:0]    dot_col_q, dot_col_d;
  logic          boundary;
  logic [7:0]    row_pat;

`ifdef MATRIX_DIM_EN
  localparam int TW = CW + 4;
  logic [TW-1:0] dim_prod;
  logic [CW:0]   dim_thr_q, dim_thr_d;

  assign dim_prod = (TW'(brightness) + TW'(1)) * TW'(ROW_HOLD);
`endif

  assign boundary = (state_q == ST_DRIVE) && (cnt_q == HOLD_LAST) && (row_idx_q == 3'd7);

  // Scan sequencer: BLANK -> DRIVE -> next row's BLANK.
  always_comb begin
    state_d   = state_q;
    row_idx_d = row_idx_q;
    cnt_d     = cnt_q;
    if (state_q == ST_BLANK) begin
      if (cnt_q == BLANK_LAST) begin
        state_d = ST_DRIVE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      if (cnt_q == HOLD_LAST) begin
        state_d   = ST_BLANK;
        cnt_d     = '0;
        row_idx_d = row_idx_q + 3'd1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Writes and commits are both locked out while a copy is pending.
  always_comb begin
    back_d    = back_q;
    front_d   = front_q;
    pending_d = pending_q;
    if (!pending_q) begin
      if (wr_valid) begin
        back_d[wr_row] = wr_data;
      end
      if (commit) begin
        pending_d = 1'b1;
      end
    end else if (boundary) begin
      front_d   = back_q;
      pending_d = 1'b0;
    end
  end

`ifdef MATRIX_DIM_EN
  always_comb begin
    dim_thr_d = dim_thr_q;
    if ((state_q == ST_BLANK) && (state_d == ST_DRIVE)) begin
      dim_thr_d = dim_prod[TW-1:3];
    end
  end
`endif

  // Outputs are decoded from the next state so they line up with state_q.
  always_comb begin
    frame_tick_d = boundary;
    dot_row_d    = 8'h00;
    dot_col_d    = COL_OFF;
    row_pat      = front_q[row_idx_d];
`ifdef MATRIX_DIM_EN
    if ({1'b0, cnt_d} >= dim_thr_d) begin
      row_pat = 8'h00;
    end
`endif
    if (state_d == ST_DRIVE) begin
      dot_row_d = 8'h01 << row_idx_d;
      dot_col_d = row_pat ^ COL_OFF;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_BLANK;
      row_idx_q    <= 3'd0;
      cnt_q        <= '0;
      pending_q    <= 1'b0;
      frame_tick_q <= 1'b0;
      dot_row_q    <= 8'h00;
      dot_col_q    <= COL_OFF;
      for (int i = 0; i < 8; i++) begin
        front_q[i] <= 8'h00;
        back_q[i]  <= 8'h00;
      end
`ifdef MATRIX_DIM_EN
      dim_thr_q <= '0;
`endif
    end else begin
      state_q      <= state_d;
      row_idx_q    <= row_idx_d;
      cnt_q        <= cnt_d;
      pending_q    <= pending_d;
      frame_tick_q <= frame_tick_d;
      dot_row_q    <= dot_row_d;
      dot_col_q    <= dot_col_d;
      front_q      <= front_d;
      back_q       <= back_d;
`ifdef MATRIX_DIM_EN
      dim_thr_q <= dim_thr_d;
`endif
    end
  end

  assign wr_ready       = !pending_q;
  assign commit_pending = pending_q;
  assign frame_tick     = frame_tick_q;
  assign dot_row        = dot_row_q;
  assign dot_col        = dot_col_q;

endmodule

// File: tb/tb_dot_matrix_scan_ctrl.sv
// Bench for dot_matrix_scan_ctrl: directed scenarios plus random traffic against a frame-position model.
// Builds with or without MATRIX_DIM_EN.
module tb_dot_matrix_scan_ctrl;
  localparam int BC = 1;
`ifdef MATRIX_DIM_EN
  localparam int RH = 8;
`else
  localparam int RH = 4;
`endif
  localparam int SLOT  = BC + RH;
  localparam int FRAME = 8 * SLOT;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       wr_valid = 1'b0;
  logic       commit = 1'b0;
  logic [2:0] wr_row = 3'd0;
  logic [7:0] wr_data = 8'h00;
  logic       wr_ready, commit_pending, frame_tick;
  logic [7:0] dot_row, dot_col;
  logic       wr_ready_i, pending_i, tick_i;
  logic [7:0] row_i, col_i;
`ifdef MATRIX_DIM_EN
  logic [2:0] brightness = 3'd7;
`endif

  always #5 clock = ~clock;

  dot_matrix_scan_ctrl #(.ROW_HOLD(RH), .BLANK_CYC(BC), .COL_INV(0)) dut (
    .clock(clock), .reset(reset), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_row(wr_row), .wr_data(wr_data), .commit(commit), .commit_pending(commit_pending),
    .frame_tick(frame_tick), .dot_row(dot_row), .dot_col(dot_col)
`ifdef MATRIX_DIM_EN
    , .brightness(brightness)
`endif
  );

  dot_matrix_scan_ctrl #(.ROW_HOLD(RH), .BLANK_CYC(BC), .COL_INV(1)) dut_inv (
    .clock(clock), .reset(reset), .wr_valid(wr_valid), .wr_ready(wr_ready_i),
    .wr_row(wr_row), .wr_data(wr_data), .commit(commit), .commit_pending(pending_i),
    .frame_tick(tick_i), .dot_row(row_i), .dot_col(col_i)
`ifdef MATRIX_DIM_EN
    , .brightness(brightness)
`endif
  );

  // Reference state: buffers, pending flag, cycle index since reset release.
  logic [7:0] m_front [8];
  logic [7:0] m_back  [8];
  logic       m_pend;
  int         m_bright;
  int         t;
  int         n_checks = 0;
  int         n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s t=%0d got %h exp %h", tag, t, got, exp);
    end
  endtask

  task automatic check_outputs();
    int pos, row, ph;
    logic [7:0] er, ec;
    logic lit;
    pos = t % FRAME;
    row = pos / SLOT;
    ph  = pos % SLOT;
    er  = 8'h00;
    ec  = 8'h00;
    if (ph >= BC) begin
      er  = 8'(1 << row);
      lit = 1'b1;
`ifdef MATRIX_DIM_EN
      lit = (ph - BC) < (((m_bright + 1) * RH) >> 3);
`endif
      if (lit) ec = m_front[row];
    end
    check("dot_row", dot_row, er);
    check("dot_col", dot_col, ec);
    check("dot_row_inv", row_i, er);
    check("dot_col_inv", col_i, ec ^ 8'hFF);
    check("frame_tick", frame_tick, (t >= FRAME) && (pos == 0));
    check("commit_pending", commit_pending, m_pend);
    check("wr_ready", wr_ready, !m_pend);
    check("pending_inv", pending_i, m_pend);
    check("tick_inv", tick_i, (t >= FRAME) && (pos == 0));
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_front[i] = 8'h00;
      m_back[i]  = 8'h00;
    end
    m_pend   = 1'b0;
    m_bright = 0;
    t        = 0;
  endtask

  task automatic model_update();
    int pos;
    pos = t % FRAME;
    if (m_pend) begin
      if (pos == FRAME - 1) begin
        m_front = m_back;
        m_pend  = 1'b0;
      end
    end else begin
      if (wr_valid) m_back[wr_row] = wr_data;
      if (commit) m_pend = 1'b1;
    end
`ifdef MATRIX_DIM_EN
    if ((pos % SLOT) == BC - 1) m_bright = int'(brightness);
`endif
    t++;
  endtask

  // One clock cycle: check outputs, drive inputs, advance model.
  task automatic step(input logic v, input logic [2:0] r, input logic [7:0] d, input logic c);
    check_outputs();
    wr_valid = v;
    wr_row   = r;
    wr_data  = d;
    commit   = c;
    @(posedge clock);
    model_update();
    @(negedge clock);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 3'd0, 8'h00, 1'b0);
  endtask

  task automatic advance_to(input int p);
    while ((t % FRAME) != p) step(1'b0, 3'd0, 8'h00, 1'b0);
  endtask

  task automatic do_reset(input int n);
    reset    = 1'b1;
    wr_valid = 1'b0;
    commit   = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      @(negedge clock);
      check("rst_dot_row", dot_row, 8'h00);
      check("rst_dot_col", dot_col, 8'h00);
      check("rst_dot_col_inv", col_i, 8'hFF);
      check("rst_pending", commit_pending, 1'b0);
      check("rst_wr_ready", wr_ready, 1'b1);
      check("rst_frame_tick", frame_tick, 1'b0);
    end
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    model_reset();
    do_reset(3);
    idle(FRAME + 7);

    for (int i = 0; i < 8; i++) step(1'b1, 3'(i), 8'hA0 + 8'(i), 1'b0);
    step(1'b0, 3'd0, 8'h00, 1'b1);
    idle(2 * FRAME);

    advance_to(5);
    step(1'b0, 3'd0, 8'h00, 1'b1);
    step(1'b1, 3'd3, 8'hFF, 1'b1);
    idle(2 * FRAME);

    step(1'b1, 3'd5, 8'h3C, 1'b1);
    idle(2 * FRAME);

    advance_to(FRAME - 1);
    step(1'b1, 3'd2, 8'h55, 1'b1);
    idle(2 * FRAME);

    advance_to(10);
    step(1'b1, 3'd4, 8'h99, 1'b1);
    advance_to(22);
    do_reset(2);
    idle(FRAME + 3);

`ifdef MATRIX_DIM_EN
    for (int i = 0; i < 8; i++) step(1'b1, 3'(i), 8'hFF, 1'b0);
    step(1'b0, 3'd0, 8'h00, 1'b1);
    idle(FRAME);
    brightness = 3'd1;
    idle(FRAME);
    brightness = 3'd7;
    idle(FRAME);
    brightness = 3'd0;
    idle(FRAME);
`endif

    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 1499) == 0) begin
        do_reset(1 + $urandom_range(0, 2));
      end
`ifdef MATRIX_DIM_EN
      if ($urandom_range(0, 49) == 0) brightness = 3'($urandom_range(0, 7));
`endif
      step($urandom_range(0, 3) == 0, 3'($urandom_range(0, 7)),
           8'($urandom_range(0, 255)), $urandom_range(0, 59) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
